gen1_descrambler: RTL and testbench
===================================

# gen1_descrambler

Gen1 (2.5 GT/s) per-lane receive descrambler, the receive-side counterpart of the 8b Gen1 transmit scrambler. It sits after the 8b/10b decoder and before the ordered-set/DLLP/TLP parsing logic, taking one decoded symbol per clock. It regenerates the transmit LFSR from COM symbols and descrambles data symbols. It passes K-symbols and TS1/TS2 ordered-set bodies unscrambled, with a fixed 6-cycle latency.

## Interface
- No parameters. Latency is fixed at 6.
- clk_i  in  1  symbol clock, one symbol per cycle
- rst_n_i  in  1  **asynchronous, active-low reset**
- data_i  in  8  decoded symbol
- k_i  in  1  1 = control (K) symbol
- descramble_enable_i  in  1  0 = pass data raw and hold the LFSR (sampled with each symbol)
- data_o  out  8  descrambled symbol
- k_o  out  1  k_i delayed
- synced_o  out  1  1 once a COM has reached the output since reset
- ts_o  out  1  1 while data_o is symbol 1..15 of a TS1/TS2 ordered set

## Operation
- Constants:
  - COM = K 0xBC
  - SKP = K 0x1C
  - TS1 ID = D 0x4A
  - TS2 ID = D 0x45
- LFSR: 16-bit register, reset 0xFFFF. It is updated on every input symbol, evaluated in priority order:
  - input is COM → next = 0xFFFF;
  - input is SKP, or descramble_enable_i = 0 → hold;
  - otherwise advance 8 steps of G(x) = x^16+x^5+x^4+x^3+1 with n = next, r = current:
    - n0=r8
    - n1=r9
    - n2=r10
    - n3=r8^r11
    - n4=r8^r9^r12
    - n5=r8^r9^r10^r13
    - n6=r9^r10^r11^r14
    - n7=r10^r11^r12^r15
    - n8=r0^r11^r12^r13
    - n9=r1^r12^r13^r14
    - n10=r2^r13^r14^r15
    - n11=r3^r14^r15
    - n12=r4^r15
    - n13..n15=r5..r7
  - K-symbols other than COM/SKP, and TS bodies, still advance the LFSR.
- Keystream for the current input symbol is r[15:8]: data bit i is XORed with r[8+i]. The input stage computes descrambled = data_i ^ r[15:8].
- Raw flag, set per symbol at input. The symbol is passed raw if any of the following holds:
  - k_i = 1;
  - descramble_enable_i = 0;
  - no COM has been seen since reset (unsynced);
  - the symbol is at position 6..15 of a TS ordered set.
- Position counter (4-bit):
  - COM loads position 0.
  - Each following symbol increments the counter, saturating at 15, after which the counter goes idle.
  - SKP at position 1 → idle.
  - A COM at any position restarts at 0.
- TS detection happens when position 6 is at the input with k_i = 0 and data_i ∈ {0x4A, 0x45}. On that edge:
  - set ts_active;
  - force raw = 1 and ts = 1 on the five pipeline entries holding positions 1..5, which at that moment are stages 0..4 shifting into 1..5.
  - Positions 6..15 enter with raw = 1, ts = 1.
  - ts_active clears at position 15 or on a new COM.
- Pipeline: 6 stages, each holding {raw data, descrambled data, k, raw, ts}. Output stage registers:
  - data_o = raw ? raw data : descrambled;
  - k_o;
  - ts_o;
  - synced_o is set when a COM leaves stage 5 and is never cleared except by reset.

## Timing
- A symbol at the input in cycle t appears on the outputs in cycle t+6. The pipeline has no stalls and no bubbles.
- Reset values (async, immediate):
  - data_o = 0x00, k_o = 0, ts_o = 0, synced_o = 0;
  - LFSR = 0xFFFF;
  - position counter idle;
  - all pipeline stages cleared.
- COM at input in cycle t0 appears at the output in cycle t0+6; the symbol at t0+1 uses keystream 0xFF.
- TS decision at cycle t0+6 is registered; ts_o is high for output cycles t0+7 .. t0+21, and low on the COM itself.
- Back-to-back COMs: each COM reseeds the LFSR. A COM arriving before position 6 cancels the pending TS decision, and the entries of the earlier OS are emitted descrambled.
- Reset mid-stream: pipeline contents are discarded, and the block resumes unsynced.

## Test plan
- Reset, then D 0x00 ×3 with no COM → data_o 0x00 ×3 at +6 cycles; synced_o = 0.
- COM, then D 0x00, D 0x00 → output COM, 0xFF, 0xE8; synced_o rises with the COM output.
- COM, SKP, SKP, SKP, D 0x00 → SKPs pass through with k_o = 1; the data symbol outputs 0xFF because the LFSR was held by the SKPs.
- TS1 (COM, K 0xF7 ×2, D 0x00 ×3, D 0x4A ×10), then D 0x00 → all 15 body symbols are output unchanged with ts_o = 1. The trailing data symbol is XORed with the keystream after 15 advances from 0xFFFF, per the model.
- COM followed by 3 data symbols, then a new COM and a TS2 → the first three are output descrambled with ts_o = 0; the TS2 body is output raw with ts_o = 1.
- descramble_enable_i = 0 for 2 symbols mid-packet → those symbols are output raw, the LFSR holds, and the next symbol uses the same keystream the first disabled symbol would have used.

Source files
------------

// File: rtl/gen1_descrambler.sv
`default_nettype none
// ============================================================================
// Module   : gen1_descrambler
// Purpose  : Gen1 per-lane receive descrambler. It reseeds the LFSR on COM,
//            passes K symbols and TS1/TS2 bodies raw, and has 6-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module gen1_descrambler (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] data_i,
    input  logic       k_i,
    input  logic       descramble_enable_i,
    output logic [7:0] data_o,
    output logic       k_o,
    output logic       synced_o,
    output logic       ts_o
);

    localparam logic [7:0] c_com      = 8'hBC;
    localparam logic [7:0] c_skp      = 8'h1C;
    localparam logic [7:0] c_ts1_id   = 8'h4A;
    localparam logic [7:0] c_ts2_id   = 8'h45;
    localparam int         c_stages   = 5;      // stages ahead of the output register
    localparam logic [3:0] c_pos_id   = 4'd6;
    localparam logic [3:0] c_pos_last = 4'd15;

    typedef struct packed {
        logic [7:0] raw_data;
        logic [7:0] descr;
        logic       k;
        logic       raw;
        logic       ts;
    } stage_t;

    // Eight serial steps of x^16+x^5+x^4+x^3+1, collapsed into one symbol update.
    function automatic logic [15:0] f_lfsr_adv8(input logic [15:0] r);
        logic [15:0] n;
        n[0]  = r[8];
        n[1]  = r[9];
        n[2]  = r[10];
        n[3]  = r[8]  ^ r[11];
        n[4]  = r[8]  ^ r[9]  ^ r[12];
        n[5]  = r[8]  ^ r[9]  ^ r[10] ^ r[13];
        n[6]  = r[9]  ^ r[10] ^ r[11] ^ r[14];
        n[7]  = r[10] ^ r[11] ^ r[12] ^ r[15];
        n[8]  = r[0]  ^ r[11] ^ r[12] ^ r[13];
        n[9]  = r[1]  ^ r[12] ^ r[13] ^ r[14];
        n[10] = r[2]  ^ r[13] ^ r[14] ^ r[15];
        n[11] = r[3]  ^ r[14] ^ r[15];
        n[12] = r[4]  ^ r[15];
        n[13] = r[5];
        n[14] = r[6];
        n[15] = r[7];
        return n;
    endfunction

    logic [15:0] r_lfsr;
    logic        r_seen_com;
    logic        r_trk;
    logic [3:0]  r_pos;
    logic        r_ts_active;
    stage_t      r_stage [c_stages];

    logic        w_is_com;
    logic        w_is_skp;
    logic [3:0]  w_pos_inc;
    logic        w_pos_live;
    logic        w_ts_detect;
    logic        w_sym_ts;
    logic        w_raw;
    stage_t      w_in;
    stage_t      w_shift [c_stages];

    assign w_is_com  = k_i && (data_i == c_com);
    assign w_is_skp  = k_i && (data_i == c_skp);
    assign w_pos_inc = r_pos + 4'd1;
    // The incoming symbol belongs to an ordered set being tracked (position 1..15).
    assign w_pos_live  = r_trk && !w_is_com;
    assign w_ts_detect = w_pos_live && (w_pos_inc == c_pos_id) && !k_i &&
                         ((data_i == c_ts1_id) || (data_i == c_ts2_id));
    assign w_sym_ts    = w_ts_detect || (r_ts_active && !w_is_com);
    assign w_raw       = k_i || !descramble_enable_i || !r_seen_com || w_sym_ts;

    always_comb begin
        w_in.raw_data = data_i;
        w_in.descr    = data_i ^ r_lfsr[15:8];
        w_in.k        = k_i;
        w_in.raw      = w_raw;
        w_in.ts       = w_sym_ts;
    end

    // A TS decision retroactively marks positions 1..5 already in flight.
    always_comb begin
        for (int s = 0; s < c_stages; s++) begin
            w_shift[s] = r_stage[s];
            if (w_ts_detect) begin
                w_shift[s].raw = 1'b1;
                w_shift[s].ts  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_lfsr <= 16'hFFFF;
        end else if (w_is_com) begin
            r_lfsr <= 16'hFFFF;
        end else if (!w_is_skp && descramble_enable_i) begin
            r_lfsr <= f_lfsr_adv8(r_lfsr);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_seen_com  <= 1'b0;
            r_trk       <= 1'b0;
            r_pos       <= 4'd0;
            r_ts_active <= 1'b0;
        end else begin
            if (w_is_com) begin
                r_seen_com  <= 1'b1;
                r_trk       <= 1'b1;
                r_pos       <= 4'd0;
                r_ts_active <= 1'b0;
            end else if (r_trk) begin
                r_pos <= w_pos_inc;
                // SKP ordered sets and completed ordered sets stop tracking.
                if ((w_pos_inc == c_pos_last) || (w_is_skp && (w_pos_inc == 4'd1))) begin
                    r_trk <= 1'b0;
                end
                if (w_ts_detect) begin
                    r_ts_active <= 1'b1;
                end else if (w_pos_inc == c_pos_last) begin
                    r_ts_active <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int s = 0; s < c_stages; s++) begin
                r_stage[s] <= '0;
            end
        end else begin
            r_stage[0] <= w_in;
            for (int s = 1; s < c_stages; s++) begin
                r_stage[s] <= w_shift[s-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_o   <= 8'h00;
            k_o      <= 1'b0;
            ts_o     <= 1'b0;
            synced_o <= 1'b0;
        end else begin
            data_o <= w_shift[c_stages-1].raw ? w_shift[c_stages-1].raw_data
                                              : w_shift[c_stages-1].descr;
            k_o    <= w_shift[c_stages-1].k;
            ts_o   <= w_shift[c_stages-1].ts;
            if (w_shift[c_stages-1].k && (w_shift[c_stages-1].raw_data == c_com)) begin
                synced_o <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gen1_descrambler.sv
`default_nettype none
// ============================================================================
// Module   : tb_gen1_descrambler
// Purpose  : Directed vector bench for gen1_descrambler (6-cycle latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gen1_descrambler;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [7:0] data_i;
    logic       k_i;
    logic       descramble_enable_i;
    logic [7:0] data_o;
    logic       k_o;
    logic       synced_o;
    logic       ts_o;

    gen1_descrambler dut (
        .clk_i               (clk_i),
        .rst_n_i             (rst_n_i),
        .data_i              (data_i),
        .k_i                 (k_i),
        .descramble_enable_i (descramble_enable_i),
        .data_o              (data_o),
        .k_o                 (k_o),
        .synced_o            (synced_o),
        .ts_o                (ts_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] d;
        logic       k;
        logic       en;
        logic [7:0] ed;
        logic       ek;
        logic       ets;
        logic       esy;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] m;
    logic        sy;
    int          n_vec = 0;
    int          n_bad = 0;

    // Bit-serial Galois form of the scrambler polynomial, stepped 8 times.
    function automatic logic [15:0] adv8(input logic [15:0] r);
        logic [15:0] x;
        logic        fb;
        x = r;
        for (int i = 0; i < 8; i++) begin
            fb = x[15];
            x  = {x[14:0], 1'b0};
            if (fb) x = x ^ 16'h0039;
        end
        return adv8_ret(x);
    endfunction

    function automatic logic [15:0] adv8_ret(input logic [15:0] x);
        return x;
    endfunction

    task automatic push(input logic [7:0] d, input logic k, input logic en,
                        input logic [7:0] ed, input logic ek, input logic ets,
                        input logic esy);
        vec_t v;
        v.d = d; v.k = k; v.en = en; v.ed = ed; v.ek = ek; v.ets = ets; v.esy = esy;
        tbl.push_back(v);
    endtask

    task automatic com();
        sy = 1'b1;
        push(8'hBC, 1'b1, 1'b1, 8'hBC, 1'b1, 1'b0, sy);
        m = 16'hFFFF;
    endtask

    task automatic skp();
        push(8'h1C, 1'b1, 1'b1, 8'h1C, 1'b1, 1'b0, sy);
    endtask

    task automatic dat(input logic [7:0] d);
        push(d, 1'b0, 1'b1, d ^ m[15:8], 1'b0, 1'b0, sy);
        m = adv8(m);
    endtask

    task automatic raw_dat(input logic [7:0] d);
        push(d, 1'b0, 1'b1, d, 1'b0, 1'b0, sy);
        m = adv8(m);
    endtask

    task automatic dis(input logic [7:0] d);
        push(d, 1'b0, 1'b0, d, 1'b0, 1'b0, sy);
    endtask

    task automatic ts_body(input logic [7:0] d, input logic k);
        push(d, k, 1'b1, d, k, 1'b1, sy);
        m = adv8(m);
    endtask

    task automatic check(input string name, input logic [7:0] ed, input logic ek,
                         input logic ets, input logic esy);
        n_vec++;
        if (data_o !== ed || k_o !== ek || ts_o !== ets || synced_o !== esy) begin
            n_bad++;
            $display("FAIL %s: got data_o=%h k_o=%b ts_o=%b synced_o=%b, expected %h %b %b %b",
                     name, data_o, k_o, ts_o, synced_o, ed, ek, ets, esy);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic k, input logic en);
        data_i = d; k_i = k; descramble_enable_i = en;
    endtask

    initial begin
        m  = 16'hFFFF;
        sy = 1'b0;

        // Unsynced data passes raw.
        raw_dat(8'h00); raw_dat(8'h00); raw_dat(8'h00);
        // First keystream bytes after a COM: 0xFF then 0xE8.
        com(); push(8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
        push(8'h00, 1'b0, 1'b1, 8'hE8, 1'b0, 1'b0, 1'b1);
        // SKP ordered set holds the LFSR.
        com(); skp(); skp(); skp(); dat(8'h00);
        // TS1 with K F7 link/lane fields.
        com();
        ts_body(8'hF7, 1'b1); ts_body(8'hF7, 1'b1);
        ts_body(8'h00, 1'b0); ts_body(8'h00, 1'b0); ts_body(8'h00, 1'b0);
        for (int i = 0; i < 10; i++) ts_body(8'h4A, 1'b0);
        dat(8'h00);
        // COM interrupting a short OS, followed by a TS2.
        com(); dat(8'h12); dat(8'h34); dat(8'h56);
        com();
        ts_body(8'hF7, 1'b1); ts_body(8'hF7, 1'b1);
        ts_body(8'h0F, 1'b0); ts_body(8'h10, 1'b0); ts_body(8'h02, 1'b0);
        for (int i = 0; i < 10; i++) ts_body(8'h45, 1'b0);
        dat(8'hA5);
        // Descrambling disabled for two symbols.
        com(); dat(8'h11); dat(8'h22); dis(8'h33); dis(8'h44); dat(8'h55); dat(8'h66);
        // Non-ID symbol at position 6 is ordinary data.
        com(); dat(8'h01); dat(8'h02); dat(8'h03); dat(8'h04); dat(8'h05); dat(8'h4B); dat(8'h4A);
        // SKP at position 1 stops tracking, so a later 0x4A is not a TS ID.
        com(); skp(); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h4A); dat(8'h4A);

        rst_n_i = 1'b0;
        drive(8'h00, 1'b0, 1'b1);
        #12;
        check("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        for (int c = 0; c < tbl.size() + 6; c++) begin
            @(negedge clk_i);
            if (c >= 6) check($sformatf("vec%0d", c - 6), tbl[c-6].ed, tbl[c-6].ek,
                              tbl[c-6].ets, tbl[c-6].esy);
            if (c < tbl.size()) drive(tbl[c].d, tbl[c].k, tbl[c].en);
            else                drive(8'h00, 1'b0, 1'b1);
        end

        // Mid-stream reset discards in-flight symbols and the synced state.
        drive(8'hBC, 1'b1, 1'b1);
        @(negedge clk_i); drive(8'h00, 1'b0, 1'b1);
        @(negedge clk_i); drive(8'h00, 1'b0, 1'b1);
        #2 rst_n_i = 1'b0;
        #1 check("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk_i);
            if (c >= 6) check($sformatf("post_reset%0d", c), 8'h5A, 1'b0, 1'b0, 1'b0);
            else        check($sformatf("post_reset%0d", c), 8'h00, 1'b0, 1'b0, 1'b0);
            drive(8'h5A, 1'b0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
